// File: rtl/fp_alu_pkg.sv
// Shared FP ALU constants: shifter geometry, shift directions and requester IDs,
// plus the result-slot state encoding used by the shifter arbiter.
package fp_alu_pkg;
  localparam int SH_WIDTH = 16;
  localparam int SH_AMTW  = 4;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins.
// The pointer starts at B so that A takes the first tie after reset.
module rr_arb2
  import fp_alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_r;

  // Grant decode; nothing is granted while disabled
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (last_r == ID_B);
        gnt_b = (last_r == ID_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Last-granted pointer, moved only by an actual grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= ID_B;
    end else if (gnt_a) begin
      last_r <= ID_A;
    end else if (gnt_b) begin
      last_r <= ID_B;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Shares one external combinational barrel shifter between the A and B requesters
// and captures the shifted value in a one-entry valid/ready result slot.
module barrel_shift_arbiter
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int AMTW  = SH_AMTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [AMTW-1:0]  a_amt,
  input  logic             a_dir,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [AMTW-1:0]  b_amt,
  input  logic             b_dir,
  output logic [WIDTH-1:0] sh_in,
  output logic [AMTW-1:0]  sh_amt,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);

  slot_state_e      state_r;
  slot_state_e      state_nxt_s;
  logic [WIDTH-1:0] res_data_r;
  logic             res_id_r;
  logic             free_s;
  logic             arb_en_s;
  logic             gnt_a_s;
  logic             gnt_b_s;
  logic             grant_s;

  // The slot can take a new result when empty or when it drains this cycle;
  // holding the arbiter off during reset keeps requests from being accepted then.
  assign free_s   = (state_r == SLOT_EMPTY) || res_ready;
  assign arb_en_s = free_s && !rst;
  assign grant_s  = gnt_a_s || gnt_b_s;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid),
    .req_b (b_valid),
    .en    (arb_en_s),
    .gnt_a (gnt_a_s),
    .gnt_b (gnt_b_s)
  );

  // Route the granted port onto the shifter lines, zero when idle
  always_comb begin
    sh_in  = {WIDTH{1'b0}};
    sh_amt = {AMTW{1'b0}};
    sh_dir = SH_LEFT;
    if (gnt_a_s) begin
      sh_in  = a_data;
      sh_amt = a_amt;
      sh_dir = a_dir;
    end else if (gnt_b_s) begin
      sh_in  = b_data;
      sh_amt = b_amt;
      sh_dir = b_dir;
    end else begin
      sh_in  = {WIDTH{1'b0}};
      sh_amt = {AMTW{1'b0}};
      sh_dir = SH_LEFT;
    end
  end

  // Result slot next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (grant_s) begin
          state_nxt_s = SLOT_FULL;
        end else begin
          state_nxt_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (grant_s) begin
          state_nxt_s = SLOT_FULL;
        end else if (res_ready) begin
          state_nxt_s = SLOT_EMPTY;
        end else begin
          state_nxt_s = SLOT_FULL;
        end
      end
      default: state_nxt_s = SLOT_EMPTY;
    endcase
  end

  // Slot state and captured shifter result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= SLOT_EMPTY;
      res_data_r <= {WIDTH{1'b0}};
      res_id_r   <= ID_A;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        res_data_r <= sh_out;
        res_id_r   <= gnt_b_s ? ID_B : ID_A;
      end else begin
        res_data_r <= res_data_r;
        res_id_r   <= res_id_r;
      end
    end
  end

  assign a_ready   = gnt_a_s;
  assign b_ready   = gnt_b_s;
  assign res_valid = (state_r == SLOT_FULL);
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: directed vector table, reset
// corner cases and a randomized run against a queue-based reference model.
module tb_barrel_shift_arbiter;
  import fp_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, a_ready, a_dir;
  logic [15:0] a_data;
  logic [3:0]  a_amt;
  logic        b_valid, b_ready, b_dir;
  logic [15:0] b_data;
  logic [3:0]  b_amt;
  logic [15:0] sh_in, sh_out;
  logic [3:0]  sh_amt;
  logic        sh_dir;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_data;

  int total = 0;
  int bad   = 0;

  barrel_shift_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_dir(a_dir),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_dir(b_dir),
    .sh_in(sh_in), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  // Stand-in for the parent's logical barrel shifter
  always_comb sh_out = (sh_dir == SH_RIGHT) ? (sh_in >> sh_amt) : (sh_in << sh_amt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic av; logic [15:0] ad; logic [3:0] aa; logic adir;
    logic bv; logic [15:0] bd; logic [3:0] ba; logic bdir;
    logic rr;
    logic ear; logic ebr; logic erv; logic [15:0] erd; logic eid;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic av, logic [15:0] ad, logic [3:0] aa, logic adir,
                              logic bv, logic [15:0] bd, logic [3:0] ba, logic bdir,
                              logic rr, logic ear, logic ebr, logic erv,
                              logic [15:0] erd, logic eid);
    vec_t v;
    v.av = av; v.ad = ad; v.aa = aa; v.adir = adir;
    v.bv = bv; v.bd = bd; v.ba = ba; v.bdir = bdir;
    v.rr = rr; v.ear = ear; v.ebr = ebr; v.erv = erv; v.erd = erd; v.eid = eid;
    return v;
  endfunction

  task automatic drive_idle();
    a_valid = 1'b0; a_data = 16'h0; a_amt = 4'h0; a_dir = 1'b0;
    b_valid = 1'b0; b_data = 16'h0; b_amt = 4'h0; b_dir = 1'b0;
  endtask

  typedef struct { logic id; logic [15:0] d; } item_t;

  initial begin
    item_t       slot_q[$];
    item_t       pend;
    int          last_g, g, prev_g, a_lost, b_lost;
    logic        prev_rr, prev_ar, prev_br, free;
    logic [15:0] exp_sh;

    drive_idle();
    res_ready = 1'b1;

    // Reset with A requesting: nothing may be accepted and all outputs read 0
    #1 rst = 1'b1;
    a_valid = 1'b1; a_data = 16'h1234; a_amt = 4'h3;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_sh_in", sh_in, 0);
    check("rst_sh_amt", sh_amt, 0);
    check("rst_sh_dir", sh_dir, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("idle_res_valid", res_valid, 0);
      check("idle_a_ready", a_ready, 0);
      check("idle_sh_in", sh_in, 0);
    end

    //          av ad       aa    ad  bv bd       ba     bd  rr ear ebr erv erd      eid
    tbl[0]  = mk(0, 16'h0000, 4'd0, 0, 0, 16'h0000, 4'd0,  0, 1, 0, 0, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 16'h0001, 4'd4, 0, 1, 16'h8000, 4'd15, 1, 1, 1, 0, 0, 16'h0000, 0);
    tbl[2]  = mk(1, 16'h0001, 4'd4, 0, 1, 16'h8000, 4'd15, 1, 1, 0, 1, 1, 16'h0010, 0);
    tbl[3]  = mk(1, 16'h0001, 4'd4, 0, 1, 16'h8000, 4'd15, 1, 1, 1, 0, 1, 16'h0001, 1);
    tbl[4]  = mk(1, 16'h0001, 4'd4, 0, 1, 16'h8000, 4'd15, 1, 1, 0, 1, 1, 16'h0010, 0);
    tbl[5]  = mk(0, 16'h0000, 4'd0, 0, 0, 16'h0000, 4'd0,  0, 1, 0, 0, 1, 16'h0001, 1);
    tbl[6]  = mk(1, 16'h0101, 4'd2, 0, 0, 16'h0000, 4'd0,  0, 0, 1, 0, 0, 16'h0000, 0);
    tbl[7]  = mk(1, 16'h0F00, 4'd3, 1, 0, 16'h0000, 4'd0,  0, 0, 0, 0, 1, 16'h0404, 0);
    tbl[8]  = mk(1, 16'h0F00, 4'd3, 1, 0, 16'h0000, 4'd0,  0, 0, 0, 0, 1, 16'h0404, 0);
    tbl[9]  = mk(1, 16'h0F00, 4'd3, 1, 0, 16'h0000, 4'd0,  0, 0, 0, 0, 1, 16'h0404, 0);
    tbl[10] = mk(1, 16'h0F00, 4'd3, 1, 0, 16'h0000, 4'd0,  0, 1, 1, 0, 1, 16'h0404, 0);
    tbl[11] = mk(0, 16'h0000, 4'd0, 0, 1, 16'hA5A5, 4'd0,  0, 1, 0, 1, 1, 16'h01E0, 0);
    tbl[12] = mk(0, 16'h0000, 4'd0, 0, 0, 16'h0000, 4'd0,  0, 1, 0, 0, 1, 16'hA5A5, 1);
    tbl[13] = mk(1, 16'h0002, 4'd1, 0, 1, 16'h0004, 4'd1,  1, 0, 1, 0, 0, 16'h0000, 0);
    tbl[14] = mk(1, 16'h0002, 4'd1, 0, 1, 16'h0004, 4'd1,  1, 0, 0, 0, 1, 16'h0004, 0);
    tbl[15] = mk(1, 16'h0002, 4'd1, 0, 1, 16'h0004, 4'd1,  1, 1, 0, 1, 1, 16'h0004, 0);
    tbl[16] = mk(1, 16'h0002, 4'd1, 0, 1, 16'h0004, 4'd1,  1, 1, 1, 0, 1, 16'h0002, 1);
    tbl[17] = mk(0, 16'h0000, 4'd0, 0, 0, 16'h0000, 4'd0,  0, 1, 0, 0, 1, 16'h0004, 0);
    tbl[18] = mk(0, 16'h0000, 4'd0, 0, 0, 16'h0000, 4'd0,  0, 1, 0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      a_valid = tbl[i].av; a_data = tbl[i].ad; a_amt = tbl[i].aa; a_dir = tbl[i].adir;
      b_valid = tbl[i].bv; b_data = tbl[i].bd; b_amt = tbl[i].ba; b_dir = tbl[i].bdir;
      res_ready = tbl[i].rr;
      #1;
      check("vec_a_ready", a_ready, tbl[i].ear);
      check("vec_b_ready", b_ready, tbl[i].ebr);
      check("vec_res_valid", res_valid, tbl[i].erv);
      if (tbl[i].erv) begin
        check("vec_res_data", res_data, tbl[i].erd);
        check("vec_res_id", res_id, tbl[i].eid);
      end
      exp_sh = tbl[i].ear ? tbl[i].ad : (tbl[i].ebr ? tbl[i].bd : 16'h0);
      check("vec_sh_in", sh_in, exp_sh);
      check("vec_sh_amt", sh_amt, tbl[i].ear ? tbl[i].aa : (tbl[i].ebr ? tbl[i].ba : 4'h0));
      check("vec_sh_dir", sh_dir, tbl[i].ear ? tbl[i].adir : (tbl[i].ebr ? tbl[i].bdir : 1'b0));
    end

    // Reset while FULL, stalled, with both requests pending
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 16'h0001; a_amt = 4'd1; a_dir = SH_LEFT;
    b_valid = 1'b1; b_data = 16'h0100; b_amt = 4'd4; b_dir = SH_RIGHT;
    res_ready = 1'b0;
    @(posedge clk); #2;
    check("mid_full", res_valid, 1);
    check("mid_stall_a", a_ready, 0);
    check("mid_stall_b", b_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_a_ready", a_ready, 0);
    check("mid_rst_b_ready", b_ready, 0);
    check("mid_rst_sh_in", sh_in, 0);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("post_rst_a_first", a_ready, 1);
    check("post_rst_b_wait", b_ready, 0);
    check("post_rst_sh_in", sh_in, 16'h0001);
    @(posedge clk); #1;
    check("post_rst_valid", res_valid, 1);
    check("post_rst_data", res_data, 16'h0002);
    check("post_rst_id", res_id, 0);

    // Randomized run against the queue model
    rst = 1'b1;
    drive_idle();
    res_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_g = 1; prev_g = -1; prev_rr = 1'b0; prev_ar = 1'b0; prev_br = 1'b0;
    a_lost = 0; b_lost = 0;
    pend.id = 1'b0; pend.d = 16'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (prev_rr && slot_q.size() > 0) void'(slot_q.pop_front());
      if (prev_g >= 0) begin
        slot_q.push_back(pend);
        last_g = prev_g;
      end
      if (!(a_valid && !prev_ar)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_data = 16'($urandom); a_amt = 4'($urandom); a_dir = 1'($urandom);
      end
      if (!(b_valid && !prev_br)) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_data = 16'($urandom); b_amt = 4'($urandom); b_dir = 1'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      free = (slot_q.size() == 0) || res_ready;
      g = -1;
      if (free) begin
        if (a_valid && b_valid) g = (last_g == 1) ? 0 : 1;
        else if (a_valid) g = 0;
        else if (b_valid) g = 1;
      end
      check("rnd_a_ready", a_ready, (g == 0));
      check("rnd_b_ready", b_ready, (g == 1));
      check("rnd_res_valid", res_valid, (slot_q.size() != 0));
      if (slot_q.size() != 0) begin
        check("rnd_res_data", res_data, slot_q[0].d);
        check("rnd_res_id", res_id, slot_q[0].id);
      end
      if (g == 0) begin
        pend.id = 1'b0;
        pend.d = a_dir ? (a_data >> a_amt) : (a_data << a_amt);
        a_lost = 0;
      end else if (free && a_valid) begin
        a_lost++;
      end
      if (g == 1) begin
        pend.id = 1'b1;
        pend.d = b_dir ? (b_data >> b_amt) : (b_data << b_amt);
        b_lost = 0;
      end else if (free && b_valid) begin
        b_lost++;
      end
      if (a_valid) check("rnd_a_starve", (a_lost <= 1), 1);
      if (b_valid) check("rnd_b_starve", (b_lost <= 1), 1);
      prev_g = g; prev_rr = res_ready; prev_ar = a_ready; prev_br = b_ready;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Shares one combinational 16-bit barrel shifter (built from `mux_16to1` slices) between two FP ALU requesters: port A (exponent-alignment path) and port B (normalization path). Each cycle it grants the shifter to at most one requester using round-robin priority and drives the shifter's data, amount and direction lines. It captures the shifter output into a one-entry result register with a valid/ready handshake toward the downstream consumer.

## Interface
- `WIDTH`, 16, data width; must match the shifter.
- `AMTW`, 4, shift-amount width, log2(WIDTH).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a shift request.
- `a_ready`  out  1  A's request accepted this cycle.
- `a_data`  in  WIDTH  operand A.
- `a_amt`  in  AMTW  shift amount A.
- `a_dir`  in  1  0 = left, 1 = right (logical).
- `b_valid`, `b_ready`, `b_data`, `b_amt`, `b_dir`: same as port A, for requester B.
- `sh_in`  out  WIDTH  operand to the shifter.
- `sh_amt`  out  AMTW  amount to the shifter.
- `sh_dir`  out  1  direction to the shifter.
- `sh_out`  in  WIDTH  combinational shifter result.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  shifted value.
- `res_id`  out  1  0 = result belongs to A, 1 = to B.

## Operation
- Output slot FSM has two states:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- Slot is free when state is EMPTY, or FULL with `res_ready`=1 (drain and refill in the same cycle).
- Grant rules, combinational, only when the slot is free:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port not granted last; `last` pointer resets to B, so A wins the first tie.
- On grant:
  - Assert the granted port's `x_ready` for that cycle.
  - Drive `sh_in`/`sh_amt`/`sh_dir` from that port.
  - At the clock edge, load `res_data`=`sh_out` and `res_id`=granted port.
  - Go to (or stay in) FULL.
  - Update `last` to the granted port.
- No grant:
  - Both `x_ready`=0.
  - `sh_*` driven to 0.
  - FULL with `res_ready`=1 goes to EMPTY.
  - FULL with `res_ready`=0 holds `res_data`/`res_id` stable.
- `x_ready` may depend combinationally on `a_valid`, `b_valid` and `res_ready`. Requesters must not make `x_valid` depend on `x_ready`.
- A request with `x_valid`=1 and `x_ready`=0 must be held unchanged by the requester. The arbiter guarantees it is granted within 2 free-slot cycles.
- `amt`=0 passes data unchanged. The block performs no arithmetic on amounts; width and fill behaviour belong to the shifter.

## Timing
- Latency: 1 cycle from accepted request to `res_valid`.
- Throughput: 1 result per cycle while `res_ready`=1.
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_id`=0.
  - `a_ready`=`b_ready`=0.
  - `sh_in`=`sh_amt`=`sh_dir`=0.
  - `last`=B.
- Reset mid-operation: an unconsumed result is discarded, and a request presented during reset is not accepted.
- Simultaneous events:
  - Drain and grant in the same cycle leave `res_valid` at 1 with the new data.
  - Both requests arriving with a full, stalled slot produce no grant and no `last` change.

## Structure
- Shared package `fp_alu_pkg` holds:
  - `SH_WIDTH`=16, `SH_AMTW`=4.
  - Direction constants `SH_LEFT`=0, `SH_RIGHT`=1.
  - Port ID constants `ID_A`=0, `ID_B`=1.
- One sub-module, `rr_arb2`: a 2-way round-robin arbiter with `last` pointer; inputs are the two requests and an enable; outputs are two one-hot grants.
- The shifter is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: all outputs 0; `res_valid` stays 0 for 10 cycles.
- A only: `a_data`=0x0001, `a_amt`=4, left, `res_ready`=1 -> `a_ready`=1 in cycle 0; cycle 1 shows `res_valid`=1, `res_data`=0x0010, `res_id`=0.
- Both valid every cycle, `res_ready`=1, B: 0x8000/right/15 -> grants alternate A,B,A,B starting with A; B results are 0x0001 with `res_id`=1.
- Stall: result FULL with `res_ready`=0 for 3 cycles while A is valid -> `a_ready`=0, `res_data` stable. When `res_ready` rises, A is granted that same cycle and the new result appears next cycle with no bubble.
- Amount 0: B 0xA5A5, amt 0 -> `res_data`=0xA5A5.
- Reset asserted while FULL and both requests pending -> `res_valid` goes to 0 immediately (async). After release, A is granted first.
